// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data_mem between the CPU MEM stage
// (c_* port) and the program/data loader (l_* port).
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   c_req/c_we/c_addr/c_wdata   CPU request fields
//   c_gnt/c_rvalid/c_rdata      CPU grant and read return
//   cpu_stall                   c_req & ~c_gnt, pipeline hold
//   l_req/l_we/l_addr/l_wdata   loader request fields
//   l_lock                      loader asks to keep the memory (burst)
//   l_gnt/l_rvalid/l_rdata      loader grant and read return
//   mem_r/mem_w/mem_addr/mem_wdata/mem_rdata   data_mem pins
//
// The CPU has priority. wait_cnt counts consecutive denied loader cycles;
// when it reaches MAX_WAIT the loader wins once. A loader grant with l_lock
// enters LOCK, where only the loader is served until it drops l_req or
// l_lock. Grants are combinational; the read owner is registered so the
// 1-cycle data_mem read data is steered to the right port.

module dmem_arb_ret #(
  parameter logic OWN_ID = 1'b0
) (
  input  logic        rd_pend,
  input  logic        rd_own,
  input  logic [31:0] mem_rdata,
  output logic        rvalid,
  output logic [31:0] rdata
);
  // One return path per port; data is zeroed unless this port owns the read.
  assign rvalid = rd_pend & (rd_own == OWN_ID);
  assign rdata  = rvalid ? mem_rdata : 32'd0;
endmodule

module dmem_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_gnt,
  output logic        c_rvalid,
  output logic [31:0] c_rdata,
  output logic        cpu_stall,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  input  logic        l_lock,
  output logic        l_gnt,
  output logic        l_rvalid,
  output logic [31:0] l_rdata,
  output logic        mem_r,
  output logic        mem_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam int NUM_PORTS = 2;   // index 0 = CPU, 1 = loader
  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       rd_pend;
  logic       rd_own;

  logic [NUM_PORTS-1:0]       rvalid_v;
  logic [NUM_PORTS-1:0][31:0] rdata_v;

  // Grants. Gated by rst_n so an asserted reset kills the memory strobes
  // immediately, not at the next edge.
  always_comb begin
    l_gnt = 1'b0;
    c_gnt = 1'b0;
    if (rst_n) begin
      if (state == LOCK) begin
        l_gnt = l_req;
      end else begin
        l_gnt = l_req & (~c_req | (wait_cnt == WAIT_LIM));
        c_gnt = c_req & ~l_gnt;
      end
    end
  end

  assign cpu_stall = c_req & ~c_gnt;

  // Winner's fields to data_mem; grants are one-hot so r/w never collide.
  always_comb begin
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (l_gnt) begin
      mem_r     = ~l_we;
      mem_w     = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end else if (c_gnt) begin
      mem_r     = ~c_we;
      mem_w     = c_we;
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB;
      wait_cnt <= 4'd0;
      rd_pend  <= 1'b0;
      rd_own   <= 1'b0;
    end else begin
      rd_pend <= mem_r;
      rd_own  <= l_gnt;
      case (state)
        ARB: begin
          if (l_gnt && l_lock) state <= LOCK;
          if (l_gnt || !l_req)
            wait_cnt <= 4'd0;
          else if (wait_cnt != WAIT_LIM)
            wait_cnt <= wait_cnt + 4'd1;
        end
        LOCK: begin
          wait_cnt <= 4'd0;
          // A beat with l_lock low is the last one of the burst.
          if (!l_req || !l_lock) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  // Per-port read return paths.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ret
    dmem_arb_ret #(.OWN_ID(1'(g))) u_ret (
      .rd_pend   (rd_pend),
      .rd_own    (rd_own),
      .mem_rdata (mem_rdata),
      .rvalid    (rvalid_v[g]),
      .rdata     (rdata_v[g])
    );
  end

  assign c_rvalid = rvalid_v[0];
  assign c_rdata  = rdata_v[0];
  assign l_rvalid = rvalid_v[1];
  assign l_rdata  = rdata_v[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we;
  logic [31:0] c_addr, c_wdata;
  logic        c_gnt, c_rvalid, cpu_stall;
  logic [31:0] c_rdata;
  logic        l_req, l_we, l_lock;
  logic [31:0] l_addr, l_wdata;
  logic        l_gnt, l_rvalid;
  logic [31:0] l_rdata;
  logic        mem_r, mem_w;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .cpu_stall(cpu_stall),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // data_mem model: synchronous single port, decodes addr[15:0]
  logic [31:0] mem [0:65535];
  always @(posedge clk) begin
    if (mem_w) mem[mem_addr[15:0]] <= mem_wdata;
    if (mem_r) mem_rdata <= mem[mem_addr[15:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
    l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0; l_lock = 0;
  endtask

  task automatic cpu(input logic we, input logic [31:0] a, input logic [31:0] d);
    c_req = 1; c_we = we; c_addr = a; c_wdata = d;
  endtask

  task automatic ldr(input logic we, input logic [31:0] a, input logic [31:0] d, input logic lk);
    l_req = 1; l_we = we; l_addr = a; l_wdata = d; l_lock = lk;
  endtask

  initial begin
    mem_rdata = 32'd0;
    mem[2] = 32'd31; mem[4] = 32'd9; mem[6] = 32'd10;
    idle();
    rst_n = 0;

    // reset: requests present but nothing may be granted
    cpu(0, 2, 0); ldr(0, 4, 0, 0);
    #2;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_mem_r", mem_r, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_c_rdata", c_rdata, 0);
    @(negedge clk); idle();
    @(negedge clk); rst_n = 1;

    // first cycle after release: CPU read addr 2
    cpu(0, 2, 0); #1;
    chk("rd_c_gnt", c_gnt, 1);
    chk("rd_mem_r", mem_r, 1);
    chk("rd_mem_addr", mem_addr, 2);
    chk("rd_stall", cpu_stall, 0);
    @(negedge clk); idle(); #1;
    chk("rd_c_rvalid", c_rvalid, 1);
    chk("rd_c_rdata", c_rdata, 31);
    chk("rd_l_rvalid", l_rvalid, 0);
    chk("rd_l_rdata", l_rdata, 0);
    chk("idle_mem_r", mem_r, 0);
    chk("idle_mem_addr", mem_addr, 0);

    // write (upper address bits passed through) then read back next cycle
    @(negedge clk); cpu(1, 32'h1234_0007, 32'h55); #1;
    chk("wr_mem_w", mem_w, 1);
    chk("wr_mem_r", mem_r, 0);
    chk("wr_mem_addr", mem_addr, 32'h1234_0007);
    chk("wr_mem_wdata", mem_wdata, 32'h55);
    @(negedge clk); cpu(0, 7, 0); #1;
    chk("rb_mem_r", mem_r, 1);
    chk("rb_mem_w", mem_w, 0);
    @(negedge clk); idle(); #1;
    chk("rb_c_rdata", c_rdata, 32'h55);

    // starvation bound: both request continuously, loader wins every 5th
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); cpu(0, 2, 0); ldr(0, 4, 0, 0); #1;
      begin
        logic el, pl;
        el = (k == 5) || (k == 10);
        pl = (k == 6);
        chk($sformatf("sv_c_gnt%0d", k), c_gnt, !el);
        chk($sformatf("sv_l_gnt%0d", k), l_gnt, el);
        chk($sformatf("sv_stall%0d", k), cpu_stall, el);
        if (k > 1) begin
          chk($sformatf("sv_l_rvalid%0d", k), l_rvalid, pl);
          chk($sformatf("sv_c_rdata%0d", k), c_rdata, pl ? 32'd0 : 32'd31);
          chk($sformatf("sv_l_rdata%0d", k), l_rdata, pl ? 32'd9 : 32'd0);
        end
      end
    end
    @(negedge clk); idle(); #1;
    chk("sv_tail_l_rdata", l_rdata, 9);
    chk("sv_tail_c_rvalid", c_rvalid, 0);

    // locked burst: CPU wins 4 cycles, loader takes 3 locked beats
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      cpu(0, 6, 0);
      if (k <= 7) ldr(1, 32'd16 + 32'(k), 32'hA0 + 32'(k), k < 7);
      else begin l_req = 0; l_lock = 0; end
      #1;
      begin
        logic el;
        el = (k >= 5) && (k <= 7);
        chk($sformatf("lk_l_gnt%0d", k), l_gnt, el);
        chk($sformatf("lk_c_gnt%0d", k), c_gnt, !el);
        chk($sformatf("lk_stall%0d", k), cpu_stall, el);
        chk($sformatf("lk_mem_w%0d", k), mem_w, el);
        if (el) chk($sformatf("lk_wdata%0d", k), mem_wdata, 32'hA0 + 32'(k));
      end
    end
    // CPU read of addr 6 returns; loader reads back a burst word
    @(negedge clk); idle(); ldr(0, 22, 0, 0); #1;
    chk("lk_c_rdata", c_rdata, 10);
    chk("lk_rb_l_gnt", l_gnt, 1);
    @(negedge clk); idle(); #1;
    chk("lk_rb_l_rdata", l_rdata, 32'hA6);

    // read ownership: L read 4, then CPU read 6
    @(negedge clk); ldr(0, 4, 0, 0); #1;
    chk("own_l_gnt", l_gnt, 1);
    @(negedge clk); idle(); cpu(0, 6, 0); #1;
    chk("own_c_gnt", c_gnt, 1);
    chk("own_l_rvalid", l_rvalid, 1);
    chk("own_l_rdata", l_rdata, 9);
    chk("own_c_rvalid_a", c_rvalid, 0);
    chk("own_c_rdata_a", c_rdata, 0);
    @(negedge clk); idle(); #1;
    chk("own_c_rvalid", c_rvalid, 1);
    chk("own_c_rdata", c_rdata, 10);
    chk("own_l_rvalid_b", l_rvalid, 0);

    // reset in the cycle after a CPU read grant
    @(negedge clk); cpu(0, 2, 0); #1;
    chk("mr_c_gnt", c_gnt, 1);
    @(negedge clk); idle(); rst_n = 0; #1;
    chk("mr_c_rvalid", c_rvalid, 0);
    chk("mr_c_rdata", c_rdata, 0);
    @(negedge clk); rst_n = 1; #1;
    chk("mr_post_c_rvalid", c_rvalid, 0);
    chk("mr_post_l_rvalid", l_rvalid, 0);
    // ARB with wait_cnt cleared: CPU beats loader on a simultaneous request
    @(negedge clk); cpu(0, 2, 0); ldr(0, 4, 0, 1); #1;
    chk("mr_arb_c_gnt", c_gnt, 1);
    chk("mr_arb_l_gnt", l_gnt, 0);
    @(negedge clk); idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port `data_mem` between the pipeline MEM stage (CPU port) and the program/data loader (L port). It grants at most one access per cycle and drives `data_mem`'s `r`, `w`, `addr` and `data_in` pins. It tracks the 1-cycle synchronous read latency and routes returned data to the requester that owned the read. It enforces CPU priority with a bounded-starvation guarantee for the loader, and supports a locked loader burst.

## Interface
- `MAX_WAIT`, default 4: consecutive denied loader cycles before the loader is forced to win; range 1–15.
- `clk`  in  1  clock; all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  CPU access request.
- `c_we`  in  1  CPU write (1) / read (0).
- `c_addr`  in  32  CPU word address.
- `c_wdata`  in  32  CPU write data.
- `c_gnt`  out  1  CPU access accepted this cycle.
- `c_rvalid`  out  1  CPU read data valid.
- `c_rdata`  out  32  CPU read data; 0 when `c_rvalid`=0.
- `cpu_stall`  out  1  `c_req & ~c_gnt`; pipeline hold.
- `l_req`, `l_we`, `l_addr`[32], `l_wdata`[32]  in  loader request fields, same meaning as the CPU fields.
- `l_lock`  in  1  loader requests burst ownership.
- `l_gnt`, `l_rvalid`, `l_rdata`[32]  out  loader grant/return, same meaning as the CPU outputs.
- `mem_r`  out  1  to `data_mem.r`.
- `mem_w`  out  1  to `data_mem.w`.
- `mem_addr`  out  32  to `data_mem.addr`.
- `mem_wdata`  out  32  to `data_mem.data_in`.
- `mem_rdata`  in  32  from `data_mem.data_out`.

## Operation
- **States:** `ARB` (normal) and `LOCK` (loader owns memory). Reset → `ARB`.
- **Grant in `ARB`:**
  - `l_gnt` = `l_req & (~c_req | wait_cnt==MAX_WAIT)`.
  - `c_gnt` = `c_req & ~l_gnt`.
- **Grant in `LOCK`:** `l_gnt` = `l_req`; `c_gnt` = 0.
- **Transitions:**
  - `ARB`→`LOCK` at the edge where `l_gnt & l_lock`.
  - `LOCK`→`ARB` at the edge where `~l_req | ~l_lock`. A granted beat with `l_lock`=0 is the final beat.
- **`wait_cnt`** (4-bit):
  - Clears to 0 on any edge where `l_gnt`=1 or `l_req`=0.
  - Otherwise increments, saturating at `MAX_WAIT`.
  - Held at 0 while in `LOCK`.
- **Memory drive:**
  - Winner's fields are muxed combinationally: `mem_w` = `gnt & we`, `mem_r` = `gnt & ~we`, `mem_addr`/`mem_wdata` = winner's.
  - With no grant: `mem_r`=`mem_w`=0, and `mem_addr`/`mem_wdata` = 0.
  - `mem_r` and `mem_w` are never both 1.
- **Read return:**
  - Registered `rd_pend` (1 bit) and `rd_own` (0 = CPU, 1 = L) capture the granted read at the edge.
  - The next cycle, the owner's `rvalid`=1 and its `rdata`=`mem_rdata`. The other port's `rdata`=0.
- **Writes:** complete at the grant edge. There is no write acknowledge beyond `gnt`.
- **Back-to-back:** a read granted the cycle after a write to the same address returns the new data.
- **Address:** passed unmodified; `data_mem` decodes only bits [15:0].

## Timing
- **Reset (async, `rst_n`=0):**
  - Immediately forces `c_gnt`, `l_gnt`, `mem_r`, `mem_w`, `c_rvalid`, `l_rvalid` = 0 and `c_rdata`, `l_rdata` = 0.
  - Clears `wait_cnt`, `rd_pend`, `rd_own`; state → `ARB`.
  - A read in flight at reset is discarded; no `rvalid` is produced after release.
- **Release:** first grant possible in the first cycle with `rst_n`=1.
- **Grant latency:** 0 cycles (combinational from `req`).
- **Read data latency:** 1 cycle after grant. Sustains 1 access/cycle.
- **Stability:** requesters hold `req` and its fields stable until the `gnt` cycle. `gnt` is valid only for the current cycle.
- **Worst-case loader wait in `ARB`:** `MAX_WAIT` cycles under continuous CPU requests; the loader wins on cycle `MAX_WAIT`+1.
- **Simultaneous requests with `wait_cnt` < `MAX_WAIT`:** CPU wins.
- **Simultaneous `l_lock` grant and `c_req`:** CPU is stalled from the following cycle until `LOCK` exits.

## Test plan
- **Reset then CPU read:** reset, then CPU read `addr`=2 with `data_mem[2]`=31 → `c_gnt`=1, `mem_r`=1 that cycle; next cycle `c_rvalid`=1, `c_rdata`=31, `l_rvalid`=0.
- **Write then read:** CPU write 0x55 to addr 7, then CPU read addr 7 the next cycle → `c_rdata`=0x55 one cycle later; `mem_r`&`mem_w` never both 1.
- **Starvation bound:** `MAX_WAIT`=4, `c_req` and `l_req` held high continuously → `c_gnt` for 4 cycles, `l_gnt` on the 5th, `cpu_stall`=1 that cycle; then CPU wins 4 more cycles; pattern repeats.
- **Locked burst:** `l_req`=`l_lock`=1 for 3 beats with `c_req`=1 throughout → 3 consecutive `l_gnt`; `c_gnt`=0 until the edge after `l_lock` drops; then CPU granted.
- **Read ownership:** alternating L read addr 4 (value 9) and CPU read addr 6 (value 10) → `l_rvalid`/`l_rdata`=9, then `c_rvalid`/`c_rdata`=10, each exactly 1 cycle after its grant.
- **Reset mid-read:** assert `rst_n`=0 in the cycle after a CPU read grant → `c_rvalid`=0 immediately; after release, no stale `rvalid` and state `ARB`.
